// File: rtl/instr_buffer_loader_pkg.sv
// Shared constants, default geometry and loader state encoding for the instruction buffer loader.
package instr_buffer_loader_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h8000_0000;
  localparam int          LOOP_START_DEF = 512;
  localparam int          MAX_ADDR_DEF   = 8191;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PAD   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } loader_state_e;

  // A zero iteration count still executes the loop body once.
  function automatic logic [15:0] iter_count(input logic [15:0] iters);
    return (iters == 16'd0) ? 16'd1 : iters;
  endfunction

endpackage

// File: rtl/instr_buffer_loader_loop_iter_counter.sv
// Saturating loop-pass counter: loaded with the pass count, decremented on each wrap, floors at 1.
module loop_iter_counter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_dec,
  input  logic        i_loop_en,
  output logic        o_last_loop
);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt > 16'd1)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_last_loop = i_loop_en && (r_cnt == 16'd1);

endmodule

// File: rtl/instr_buffer_loader.sv
// Instruction buffer write front end: streams host words into BRAM and hands the program to the reader.
// Build option SOFTMC_LOOP_PAD_EN enables automatic NOP padding up to LOOP_START for an early loop word.
module instr_buffer_loader
  import instr_buffer_loader_pkg::*;
#(
  parameter int WIDTH      = 13,
  parameter int MAX_ADDR   = MAX_ADDR_DEF,
  parameter int LOOP_START = LOOP_START_DEF,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_loop,
  input  logic              in_last,
  input  logic [15:0]       loop_iters,
  output logic              in_ready,
  output logic              bram_we,
  output logic [WIDTH-1:0]  bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [WIDTH-1:0]  wr_addr,
  output logic              loop_en,
  output logic              looping,
  output logic              last_loop,
  input  logic              end_of_loop,
  input  logic              buffer_reset,
  output logic              error
);

  localparam logic [WIDTH-1:0] LP_LS  = WIDTH'(LOOP_START);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_ADDR);

  loader_state_e     r_state, w_state_next;
  logic              r_rdy;
  logic [WIDTH-1:0]  r_wr_addr, w_addr_next, w_base, w_wr_addr;
  logic              r_loop_en, w_loop_en_next, w_seen;
  logic              r_error, w_err_set, w_err_clr, w_fault;
  logic              r_looping;
  logic              r_bram_we, w_wr_en;
  logic [WIDTH-1:0]  r_bram_addr;
  logic [DATA_W-1:0] r_bram_din, w_wr_data;
  logic              w_accept, w_cnt_load, w_dec;
  logic [15:0]       w_cnt_val;
`ifdef SOFTMC_LOOP_PAD_EN
  localparam logic [DATA_W-1:0] LP_NOP = DATA_W'(NOP_INSTR);
  logic [DATA_W-1:0] r_held_data;
  logic              r_held_last, w_hold;
`endif

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on loader state, never on in_valid.
  assign in_ready = r_rdy && ((r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_DRAIN));
  assign w_accept = in_valid && in_ready;
  assign w_base   = (r_state == ST_IDLE) ? '0 : r_wr_addr;
  assign w_seen   = (r_state != ST_IDLE) && r_loop_en;
  assign w_dec    = (r_state == ST_RUN) && end_of_loop && !buffer_reset;

  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_wr_addr;
    w_loop_en_next = r_loop_en;
    w_err_set      = 1'b0;
    w_err_clr      = 1'b0;
    w_fault        = 1'b0;
    w_wr_en        = 1'b0;
    w_wr_addr      = r_wr_addr;
    w_wr_data      = in_data;
    w_cnt_load     = 1'b0;
    w_cnt_val      = iter_count(loop_iters);
`ifdef SOFTMC_LOOP_PAD_EN
    w_hold         = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_accept) begin
          w_addr_next = w_base;
          if (r_state == ST_IDLE) begin
            w_err_clr      = 1'b1;
            w_loop_en_next = 1'b0;
          end
          if (in_loop && (w_seen || (w_base > LP_LS))) begin
            w_fault = 1'b1;
`ifdef SOFTMC_LOOP_PAD_EN
          end else if (in_loop && (w_base < LP_LS)) begin
            w_hold       = 1'b1;
            w_cnt_load   = in_last;
            w_state_next = ST_PAD;
`else
          end else if (in_loop && (w_base != LP_LS)) begin
            w_fault = 1'b1;
`endif
          end else begin
            w_wr_en     = 1'b1;
            w_wr_addr   = w_base;
            w_addr_next = w_base + 1'b1;
            if (in_loop) w_loop_en_next = 1'b1;
            if (in_last) begin
              w_cnt_load   = 1'b1;
              w_state_next = ST_RUN;
            end else if (w_base == LP_MAX) begin
              w_err_set    = 1'b1;
              w_state_next = ST_DRAIN;
            end else begin
              w_state_next = ST_LOAD;
            end
          end
          // A faulting beat that is also the last one has nothing left to drain.
          if (w_fault) begin
            w_err_set    = 1'b1;
            w_state_next = in_last ? ST_IDLE : ST_DRAIN;
          end
        end
      end
`ifdef SOFTMC_LOOP_PAD_EN
      ST_PAD: begin
        w_wr_en     = 1'b1;
        w_addr_next = r_wr_addr + 1'b1;
        if (r_wr_addr != LP_LS) begin
          w_wr_data = LP_NOP;
        end else begin
          w_wr_data      = r_held_data;
          w_loop_en_next = 1'b1;
          if (r_held_last) begin
            w_state_next = ST_RUN;
          end else if (r_wr_addr == LP_MAX) begin
            w_err_set    = 1'b1;
            w_state_next = ST_DRAIN;
          end else begin
            w_state_next = ST_LOAD;
          end
        end
      end
`endif
      ST_RUN: begin
        if (buffer_reset) begin
          w_state_next   = ST_IDLE;
          w_addr_next    = '0;
          w_loop_en_next = 1'b0;
          w_cnt_load     = 1'b1;
          w_cnt_val      = 16'd0;
        end
      end
      ST_DRAIN: begin
        if (w_accept && in_last) begin
          w_state_next   = ST_IDLE;
          w_loop_en_next = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rdy       <= 1'b0;
      r_wr_addr   <= '0;
      r_loop_en   <= 1'b0;
      r_error     <= 1'b0;
      r_looping   <= 1'b0;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rdy     <= 1'b1;
      r_wr_addr <= w_addr_next;
      r_loop_en <= w_loop_en_next;
      r_error   <= w_err_set || (r_error && !w_err_clr);
      // Lags RUN entry by a cycle so the final word is already in BRAM.
      r_looping <= (r_state == ST_RUN) && !buffer_reset;
      r_bram_we <= w_wr_en;
      if (w_wr_en) begin
        r_bram_addr <= w_wr_addr;
        r_bram_din  <= w_wr_data;
      end
    end
  end

`ifdef SOFTMC_LOOP_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held_data <= '0;
      r_held_last <= 1'b0;
    end else if (w_hold) begin
      r_held_data <= in_data;
      r_held_last <= in_last;
    end
  end
`endif

  loop_iter_counter u_iter_cnt (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_load      (w_cnt_load),
    .i_load_val  (w_cnt_val),
    .i_dec       (w_dec),
    .i_loop_en   (r_loop_en),
    .o_last_loop (last_loop)
  );

  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;
  assign wr_addr   = r_wr_addr;
  assign loop_en   = r_loop_en;
  assign looping   = r_looping;
  assign error     = r_error;

endmodule
